// File: rtl/fft_bitrev_feeder.sv
// fft_bitrev_feeder
//   Takes one frame of N complex samples in natural order over a valid/ready
//   handshake, stores it, then streams it out in bit-reversed index order.
//   out_start marks the sample at natural index 0, out_last the one at N-1.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     input handshake; in_r/in_i signed sample parts
//   out_valid/out_ready   output handshake; out_r/out_i signed sample parts
//   out_start, out_last   frame markers, qualified by out_valid
//   busy                  a partial frame is held or a frame awaits draining
//
// Build option
//   FFT_BITREV_PINGPONG_EN  two banks; loading frame k+1 overlaps draining
//                           frame k (full flags replace the FILL/DRAIN FSM)
//
// State table (single-bank build)
//   state    | meaning
//   ST_FILL  | accepting samples into the buffer, wr_cnt = next natural index
//   ST_DRAIN | emitting buf[bitrev(rd_cnt)], input stalled
module fft_bitrev_feeder #(
    parameter int DW   = 17,
    parameter int N    = 32,
    parameter int LOGN = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i,
    output logic                 out_start,
    output logic                 out_last,
    output logic                 busy
);

    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
        return r;
    endfunction

    logic [LOGN-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOGN-1:0] rd_cnt_q, rd_cnt_d;
    logic            accept, xfer, fill_done, drain_done;
    logic [2*DW-1:0] rd_word;

    assign accept     = in_valid && in_ready;
    assign xfer       = out_valid && out_ready;
    assign fill_done  = accept && (wr_cnt_q == LAST_IDX);
    assign drain_done = xfer && (rd_cnt_q == LAST_IDX);

`ifdef FFT_BITREV_PINGPONG_EN
    // Bank select is the address MSB, so each bank is a contiguous half.
    logic [2*DW-1:0] mem_q [2*N];
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [1:0]      full_q, full_d;

    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        busy      = (wr_cnt_q != '0) || (full_q != 2'b00);
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        // A bank being filled is never full, and a bank being drained is
        // always full, so these two updates never target the same flag.
        if (fill_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end
        if (drain_done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[{wr_bank_q, wr_cnt_q}] <= {in_r, in_i};
    end

    assign rd_word = mem_q[{rd_bank_q, bitrev(rd_cnt_q)}];
`else
    typedef enum logic {ST_FILL, ST_DRAIN} state_t;

    logic [2*DW-1:0] mem_q [N];
    state_t          state_q, state_d;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_FILL: begin
                in_ready = 1'b1;
                if (fill_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (drain_done) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
        busy = (wr_cnt_q != '0) || (state_q == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FILL;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_cnt_q] <= {in_r, in_i};
    end

    assign rd_word = mem_q[bitrev(rd_cnt_q)];
`endif

    // N is a power of two, so the counters wrap to 0 on their own after N-1.
    always_comb begin
        wr_cnt_d = accept ? wr_cnt_q + 1'b1 : wr_cnt_q;
        rd_cnt_d = xfer   ? rd_cnt_q + 1'b1 : rd_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Outputs are forced to zero whenever nothing is being presented, so a
    // stale buffer word never leaks onto the bus.
    always_comb begin
        out_r     = out_valid ? rd_word[2*DW-1:DW] : '0;
        out_i     = out_valid ? rd_word[DW-1:0]    : '0;
        out_start = out_valid && (rd_cnt_q == '0);
        out_last  = out_valid && (rd_cnt_q == LAST_IDX);
    end

endmodule

// File: doc/fft_bitrev_feeder.md
Name: fft_bitrev_feeder

Overview:
Input-side counterpart of the FFT output reorder buffer. It accepts one frame of N complex samples in natural order over a valid/ready handshake and stores the frame in a register array. It then streams the frame out in bit-reversed index order with frame-start and frame-last markers. This lets a natural-order source drive stages that consume bit-reversed data, and lets a natural-order reference stream be converted into the FFT's bit-reversed output order for checking.

Parameters:
DW, 17, signed sample width of the real and imaginary parts
N, 32, frame length in complex samples (power of 2)
LOGN, 5, log2(N); width of the index counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample present
in_ready  out  1  block can accept an input sample
in_r  in  DW  input real part, signed
in_i  in  DW  input imaginary part, signed
out_valid  out  1  output sample present
out_ready  in  1  downstream accepts the output sample
out_r  out  DW  output real part, signed
out_i  out  DW  output imaginary part, signed
out_start  out  1  marks the first sample of a frame (natural index 0)
out_last  out  1  marks the final sample of a frame (natural index N-1)
busy  out  1  high when any sample is held or a frame is in progress

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: state=FILL, wr_cnt=0, rd_cnt=0, in_ready=1, out_valid=0, out_start=0, out_last=0, busy=0, out_r=0, out_i=0.
- The buffer array is not reset. Its contents are don't-care until written.
- States: FILL and DRAIN.
- FILL:
  - in_ready=1.
  - An accept is in_valid && in_ready at a rising edge; it writes buf[wr_cnt] <= {in_r, in_i}, then wr_cnt increments.
  - An accept with wr_cnt==N-1 wraps wr_cnt to 0 and moves the block to DRAIN.
  - in_valid gaps are allowed and have no effect.
- DRAIN:
  - in_ready=0.
  - out_valid=1. out_r/out_i are driven combinationally from buf[bitrev(rd_cnt)].
  - bitrev reverses all LOGN bits (rd_cnt 1 -> index 16, 2 -> 8, 3 -> 24).
  - out_start = (rd_cnt==0); out_last = (rd_cnt==N-1).
  - A transfer is out_valid && out_ready. Each transfer increments rd_cnt.
  - A transfer with rd_cnt==N-1 wraps rd_cnt to 0 and returns the block to FILL.
  - When out_ready=0, out_r, out_i, out_start and out_last hold stable.
- Latency: the first output is valid in the cycle after the N-th input accept. Minimum frame period is 2N cycles.
- When out_valid=0, out_r, out_i, out_start and out_last are driven to 0.
- busy = (wr_cnt!=0) || (state==DRAIN).
- Data passes through bit-exact: no rounding, saturation or sign change. Signed extremes must pass unchanged.
- Reset asserted mid-FILL or mid-DRAIN aborts the frame immediately. The next accepted sample after reset is natural index 0.
- in_valid asserted during DRAIN is ignored; no sample is lost because in_ready=0.

Optional Feature:
Macro: FFT_BITREV_PINGPONG_EN
- Defined:
  - Two banks, each with a full flag, plus wr_bank and rd_bank pointers. All reset to 0.
  - in_ready = !full[wr_bank]. Completing a fill sets full[wr_bank] and toggles wr_bank.
  - out_valid = full[rd_bank]. Completing a drain clears full[rd_bank] and toggles rd_bank.
  - A fill completion and a drain completion in the same cycle are both applied.
  - Loading frame k+1 overlaps draining frame k. Sustained throughput is 1 sample per cycle with zero bubbles when in_valid=out_ready=1.
  - busy = (wr_cnt!=0) || full[0] || full[1].
- Undefined: single bank, FILL/DRAIN behaviour exactly as above.

Test Plan:
- Ramp: load in_r=k, in_i=-k for k=0..31 with out_ready=1 -> out_r sequence 0,16,8,24,4,20,...,15,31 with out_i equal to -out_r; out_start only on the first (0), out_last only on the last (31); first out_valid one cycle after the 32nd accept.
- Input gaps plus backpressure: in_valid toggled randomly, out_ready held low for 3 cycles at rd_cnt=5 -> output holds index 20 for 4 cycles, sequence otherwise unchanged; in_ready=0 throughout DRAIN.
- Extremes: in_r=-65536, in_i=65535 at k=1 -> emitted at output position 16 bit-exact.
- Back-to-back frames, two ramps offset by 100:
  - Macro undefined -> frame 2 accepts start exactly after frame 1's out_last transfer.
  - Macro defined -> 64 continuous outputs with no out_valid gap; frame 2 values start at 100.
- Reset at rd_cnt=10 during DRAIN -> all outputs 0 next cycle, in_ready=1, busy=0; a following full frame drains correctly starting with out_start.
- Reset during FILL at wr_cnt=20 -> the next 32 accepts form a complete new frame; no data from the aborted partial frame appears.
